// File: rtl/pe_dot_ctrl.sv
// Dot-product sequencer for a single multiply-accumulate PE.
// Clears the PE, streams operand pairs, then presents the 65-bit sum.
module pe_dot_ctrl #(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              pe_rst,
   output logic              pe_load,
   output logic [DATA_W-1:0] pe_row,
   output logic [DATA_W-1:0] pe_col,
   input  logic              pe_done,
   input  logic [64:0]       pe_result,
   output logic              res_valid,
   output logic [64:0]       res_data,
   input  logic              res_ready,
   output logic              err_timeout
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      IDLE, CLEAR, FETCH, LOAD, WAIT, RESULT
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [TW-1:0]    timer;
   logic             xfer;

   // Both operands move together so row and col never drift apart.
   assign xfer      = (state == FETCH) && a_valid && b_valid;
   assign a_ready   = xfer;
   assign b_ready   = xfer;
   assign busy      = (state != IDLE);
   assign pe_rst    = rst | (state == CLEAR);
   assign pe_load   = (state == LOAD);
   assign res_valid = (state == RESULT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         remaining   <= '0;
         timer       <= '0;
         pe_row      <= '0;
         pe_col      <= '0;
         res_data    <= '0;
         err_timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  remaining   <= len;
                  err_timeout <= 1'b0;
                  state       <= CLEAR;
               end
            end
            CLEAR: begin
               if (remaining == '0) begin
                  res_data <= '0;
                  state    <= RESULT;
               end else begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (xfer) begin
                  pe_row <= a_data;
                  pe_col <= b_data;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= timer + TW'(1);
               // A done on the final timer cycle still counts.
               if (pe_done) begin
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     res_data <= pe_result;
                     state    <= RESULT;
                  end else begin
                     state <= FETCH;
                  end
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end
            end
            RESULT: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// Bench for pe_dot_ctrl: behavioural PE with adjustable latency,
// table vectors, corner sequences and randomized dot products.
module tb_pe_dot_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        a_valid, b_valid;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        pe_rst, pe_load;
   logic [31:0] pe_row, pe_col;
   logic        pe_done;
   logic [64:0] pe_result;
   logic        res_valid;
   logic [64:0] res_data;
   logic        res_ready;
   logic        err_timeout;

   int n_run  = 0;
   int n_fail = 0;
   int pe_lat = 1;
   bit pe_stuck = 1'b0;

   always #5 clk = ~clk;

   pe_dot_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .pe_rst(pe_rst), .pe_load(pe_load),
      .pe_row(pe_row), .pe_col(pe_col),
      .pe_done(pe_done), .pe_result(pe_result),
      .res_valid(res_valid), .res_data(res_data),
      .res_ready(res_ready), .err_timeout(err_timeout)
   );

   // Behavioural PE: accumulates row*col pe_lat cycles after each load.
   logic [63:0] pend;
   int          cnt;
   always @(posedge clk) begin
      pe_done <= 1'b0;
      if (pe_rst) begin
         pe_result <= '0;
         pend      <= '0;
         cnt       <= 0;
      end else if (pe_load) begin
         pend <= 64'(pe_row) * 64'(pe_col);
         cnt  <= pe_lat;
      end else if (cnt == 1) begin
         pe_result <= pe_result + 65'(pend);
         pe_done   <= !pe_stuck;
         cnt       <= 0;
      end else if (cnt > 1) begin
         cnt <= cnt - 1;
      end
   end

   task automatic chk(input string nm, input logic [64:0] act,
                      input logic [64:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_dot(input string nm, input int n,
                          input logic [7:0][31:0] av,
                          input logic [7:0][31:0] bv,
                          input logic [64:0] ex, input int hold);
      int idx = 0, loads = 0, rsts = 0, cyc = 0, hl = hold;
      bit got = 0, snapped = 0, xf;
      logic [64:0] snap = '0;
      @(negedge clk);
      start = 1'b1;
      len   = 8'(n);
      @(negedge clk);
      start = 1'b0;
      while (!got && cyc < 2000) begin
         if (idx < n) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_data  = av[idx];
            b_data  = bv[idx];
         end else begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_data  = $urandom;
            b_data  = $urandom;
         end
         #1;
         if (cyc == 0) chk({nm, "_err_clr"}, 65'(err_timeout), 65'd0);
         chk({nm, "_joint"}, 65'(a_ready), 65'(b_ready));
         chk({nm, "_rdy_nv"}, 65'(a_ready & ~(a_valid & b_valid)), 65'd0);
         chk({nm, "_overfetch"}, 65'(a_ready && idx >= n), 65'd0);
         xf = a_ready;
         loads += int'(pe_load);
         rsts  += int'(pe_rst);
         if (res_valid) begin
            if (hl > 0) begin
               if (!snapped) snap = res_data;
               else chk({nm, "_stable"}, res_data, snap);
               snapped = 1;
               start = 1'b1;
               hl--;
            end else begin
               res_ready = 1'b1;
               got = 1;
               chk({nm, "_res"}, res_data, ex);
            end
         end
         @(posedge clk);
         if (xf) idx++;
         @(negedge clk);
         start     = 1'b0;
         res_ready = 1'b0;
         cyc++;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      chk({nm, "_done"}, 65'(got), 65'd1);
      chk({nm, "_loads"}, 65'(loads), 65'(n));
      chk({nm, "_pe_rst"}, 65'(rsts), 65'd1);
      chk({nm, "_idle"}, {63'd0, busy, res_valid}, 65'd0);
   endtask

   task automatic run_timeout(input string nm);
      int w = 0;
      bit seen = 0, rv = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 8'd2;
      @(negedge clk);
      start   = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 32'd5;
      b_data  = 32'd6;
      for (int c = 0; c < 300; c++) begin
         #1;
         rv |= res_valid;
         if (seen && busy) w++;
         if (pe_load) seen = 1;
         if (seen && !busy) break;
         @(negedge clk);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      chk({nm, "_wait_cyc"}, 65'(w), 65'd64);
      chk({nm, "_err"}, 65'(err_timeout), 65'd1);
      chk({nm, "_busy"}, 65'(busy), 65'd0);
      chk({nm, "_no_res"}, 65'(rv), 65'd0);
   endtask

   typedef struct packed {
      logic [7:0]       n;
      logic [7:0][31:0] a;
      logic [7:0][31:0] b;
      logic [64:0]      ex;
      logic [7:0]       hold;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [7:0][31:0] av, bv;
      logic [64:0] ex;
      int xf, n;
      bit got;

      tbl[0] = '{8'd3, {160'd0, 32'd4, 32'd3, 32'd2},
                 {160'd0, 32'd7, 32'd6, 32'd5}, 65'd56, 8'd0};
      tbl[1] = '{8'd0, 256'd0, 256'd0, 65'd0, 8'd2};
      tbl[2] = '{8'd2, {192'd0, 32'd1, 32'hFFFFFFFF},
                 {192'd0, 32'd1, 32'hFFFFFFFF},
                 65'h0_FFFFFFFE_00000002, 8'd10};
      tbl[3] = '{8'd1, {224'd0, 32'd7}, {224'd0, 32'd9},
                 65'd63, 8'd1};
      tbl[4] = '{8'd4, {128'd0, 32'd4, 32'd3, 32'd2, 32'd1},
                 {128'd0, 32'd40, 32'd30, 32'd20, 32'd10},
                 65'd300, 8'd0};
      tbl[5] = '{8'd2, {192'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                 {192'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                 65'h1_FFFFFFFC_00000002, 8'd3};

      rst = 1'b1; start = 1'b0; len = '0;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pe_rst", 65'(pe_rst), 65'd1);
      chk("rst_busy", 65'(busy), 65'd0);
      chk("rst_outs", {60'd0, a_ready, b_ready, pe_load, res_valid,
          err_timeout}, 65'd0);
      chk("rst_row", 65'(pe_row), 65'd0);
      chk("rst_res", res_data, 65'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_pe_rst", 65'(pe_rst), 65'd0);

      for (int i = 0; i < 6; i++) begin
         pe_lat = 1 + i % 3;
         run_dot($sformatf("tbl%0d", i), int'(tbl[i].n), tbl[i].a,
                 tbl[i].b, tbl[i].ex, int'(tbl[i].hold));
      end

      // b withheld: no partial handshake, then one joint transfer.
      pe_lat = 2;
      @(negedge clk);
      start = 1'b1; len = 8'd1;
      @(negedge clk);
      start = 1'b0;
      a_valid = 1'b1; a_data = 32'd11;
      b_valid = 1'b0; b_data = 32'd13;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("bhold_ardy", {63'd0, a_ready, b_ready}, 65'd0);
         chk("bhold_load", 65'(pe_load), 65'd0);
         @(negedge clk);
      end
      b_valid = 1'b1;
      xf = 0; got = 0;
      for (int c = 0; c < 50 && !got; c++) begin
         #1;
         xf += int'(a_ready);
         if (res_valid) begin
            got = 1;
            chk("bhold_res", res_data, 65'd143);
            res_ready = 1'b1;
         end
         @(negedge clk);
      end
      res_ready = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      chk("bhold_xfers", 65'(xf), 65'd1);
      chk("bhold_done", 65'(got), 65'd1);

      pe_stuck = 1'b1;
      run_timeout("stuck");
      pe_stuck = 1'b0;
      pe_lat = 2;
      run_dot("after_to", 1, {224'd0, 32'd3}, {224'd0, 32'd4},
              65'd12, 0);
      chk("err_cleared", 65'(err_timeout), 65'd0);

      pe_lat = 64;
      run_timeout("late64");
      pe_lat = 63;
      run_dot("edge63", 1, {224'd0, 32'd3}, {224'd0, 32'd4},
              65'd12, 0);

      // Reset while waiting on the PE.
      pe_lat = 10;
      @(negedge clk);
      start = 1'b1; len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = 32'd9; b_data = 32'd9;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (pe_load) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk("mid_busy", 65'(busy), 65'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_pe_rst", 65'(pe_rst), 65'd1);
      chk("mid_outs", {59'd0, busy, a_ready, b_ready, pe_load,
          res_valid, err_timeout}, 65'd0);
      chk("mid_row_col", {1'b0, pe_row, pe_col}, 65'd0);
      chk("mid_res", res_data, 65'd0);
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(0, 6);
         ex = '0;
         av = '0;
         bv = '0;
         for (int i = 0; i < n; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom;
            if (r % 4 == 0) av[i] = 32'hFFFFFFFF;
            ex += 65'(64'(av[i]) * 64'(bv[i]));
         end
         pe_lat = $urandom_range(1, 5);
         run_dot($sformatf("rnd%0d", r), n, av, bv, ex,
                 $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
